// File: rtl/ram_burst_ctrl.sv
// Burst controller for a single-port RAM with registered read data.
// Write bursts are paced by a valid stream; read bursts issue one address per cycle.
module ram_burst_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [ADDR_WIDTH-1:0] req_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  done,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  state_t                  state_r, state_s;
  logic [ADDR_WIDTH-1:0]   cur_addr_r, cur_addr_s;
  logic [ADDR_WIDTH-1:0]   remaining_r, remaining_s;
  logic                    rd_valid_r;
  logic                    done_r;
  logic                    last_beat_s;

  // Next-state, address/count update and RAM-side outputs
  always_comb begin
    state_s     = state_r;
    cur_addr_s  = cur_addr_r;
    remaining_s = remaining_r;
    last_beat_s = 1'b0;
    req_ready   = 1'b0;
    wr_ready    = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = cur_addr_r;
    ram_din     = '0;
    case (state_r)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cur_addr_s  = req_addr;
          remaining_s = req_len;
          state_s     = req_write ? WRITE : READ;
        end else begin
          state_s = IDLE;
        end
      end
      WRITE: begin
        wr_ready = 1'b1;
        ram_we   = wr_valid;
        ram_din  = wr_data;
        if (wr_valid) begin
          cur_addr_s = cur_addr_r + ADDR_ONE;
          // remaining parks at zero after the final beat
          if (remaining_r == '0) begin
            last_beat_s = 1'b1;
            state_s     = IDLE;
          end else begin
            remaining_s = remaining_r - ADDR_ONE;
          end
        end else begin
          state_s = WRITE;
        end
      end
      READ: begin
        cur_addr_s = cur_addr_r + ADDR_ONE;
        if (remaining_r == '0) begin
          last_beat_s = 1'b1;
          state_s     = IDLE;
        end else begin
          remaining_s = remaining_r - ADDR_ONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, burst counters and registered status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cur_addr_r  <= '0;
      remaining_r <= '0;
      rd_valid_r  <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cur_addr_r  <= cur_addr_s;
      remaining_r <= remaining_s;
      rd_valid_r  <= (state_r == READ);
      done_r      <= last_beat_s;
    end
  end

  assign rd_valid = rd_valid_r;
  assign done     = done_r;
  assign rd_data  = ram_dout;

endmodule
